// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter index, code table, receiver states and the table lookup.
package morse_pkg;

    typedef logic [2:0] letter_t;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] size;
    } morse_code_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic    hit;
        letter_t idx;
    } lookup_t;

    // First symbol sits at bit size-1, dash=1, unused upper bits are zero.
    localparam morse_code_t MORSE_TABLE [8] = '{
        '{code: 4'b0001, size: 3'd2},   // A .-
        '{code: 4'b1000, size: 3'd4},   // B -...
        '{code: 4'b1010, size: 3'd4},   // C -.-.
        '{code: 4'b0100, size: 3'd3},   // D -..
        '{code: 4'b0000, size: 3'd1},   // E .
        '{code: 4'b0010, size: 3'd4},   // F ..-.
        '{code: 4'b0110, size: 3'd3},   // G --.
        '{code: 4'b0000, size: 3'd4}    // H ....
    };

    function automatic lookup_t morse_lookup(input logic [3:0] code, input logic [2:0] size);
        lookup_t res;
        res = '{hit: 1'b0, idx: 3'd0};
        for (int i = 0; i < 8; i++) begin
            if ((MORSE_TABLE[i].size == size) && (MORSE_TABLE[i].code == code)) begin
                res.hit = 1'b1;
                res.idx = letter_t'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/morse_receiver_if.sv
// Lamp-line inputs and decoded-letter outputs of the Morse receiver.
interface morse_receiver_if;
    import morse_pkg::*;

    logic       dot_i;
    logic       dash_i;
    letter_t    letter_o;
    logic [2:0] len_o;
    logic       valid_o;
    logic       err_o;
    logic       busy_o;

    modport master (output dot_i, dash_i, input letter_o, len_o, valid_o, err_o, busy_o);
    modport slave  (input dot_i, dash_i, output letter_o, len_o, valid_o, err_o, busy_o);
endinterface

// File: rtl/morse_unit_timer.sv
// Time-unit timer: tick every TICK_CYCLES clocks since restart, saturating unit count.
module morse_unit_timer #(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int UNIT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart_i,
    output logic              tick_o,
    output logic [UNIT_W-1:0] units_o
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [UNIT_W-1:0] units_q, units_d;

    // Next counter values; tick is taken from the registered count to keep it loop-free.
    always_comb begin
        tick_o  = (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        units_d = units_q;
        if (restart_i) begin
            cnt_d   = '0;
            units_d = '0;
        end else if (tick_o) begin
            cnt_d   = '0;
            units_d = (units_q == {UNIT_W{1'b1}}) ? units_q : units_q + UNIT_W'(1);
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            units_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            units_q <= units_d;
        end
    end

    assign units_o = units_q;

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: captures dot/dash marks, ends a letter on an idle gap, decodes to A..H.
// Optional MORSE_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module morse_receiver
    import morse_pkg::*;
#(
    parameter int TICK_CYCLES    = 25_000_000,
    parameter int GAP_UNITS      = 3,
    parameter int MAX_MARK_UNITS = 4
) (
    input  logic            CLOCK_50,
    input  logic            rst,
    morse_receiver_if.slave rx
);

    localparam logic [2:0] GAP_LAST   = 3'(GAP_UNITS - 1);
    localparam logic [2:0] MARK_LIMIT = 3'(MAX_MARK_UNITS);

    logic       dot_s, dash_s, line_s, rise_s, both_s;
    logic       line_prev_q;
    logic       restart_s, tick_s;
    logic [2:0] units_s;
    rx_state_t  state_q, state_d;
    logic [3:0] code_q;
    logic [2:0] len_q;
    lookup_t    lookup_s;
    letter_t    letter_q, letter_d;
    logic [2:0] len_out_q, len_out_d;
    logic       valid_q, valid_d, err_q, err_d, busy_q, busy_d;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] dot_sync_q, dash_sync_q;

    // Two-flop synchronizer for the lamp lines from another clock domain.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            dot_sync_q  <= 2'b00;
            dash_sync_q <= 2'b00;
        end else begin
            dot_sync_q  <= {dot_sync_q[0], rx.dot_i};
            dash_sync_q <= {dash_sync_q[0], rx.dash_i};
        end
    end

    assign dot_s  = dot_sync_q[1];
    assign dash_s = dash_sync_q[1];
`else
    assign dot_s  = rx.dot_i;
    assign dash_s = rx.dash_i;
`endif

    assign line_s = dot_s | dash_s;
    assign both_s = dot_s & dash_s;
    assign rise_s = line_s & ~line_prev_q;

    // Previous line level for edge detection; zero after reset so a held line counts as a rise.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            line_prev_q <= 1'b0;
        end else begin
            line_prev_q <= line_s;
        end
    end

    // ERR keeps restarting while a line is high, so only an unbroken quiet gap releases it.
    assign restart_s = (state_d != state_q) || ((state_q == ERR) && line_s);

    morse_unit_timer #(.TICK_CYCLES(TICK_CYCLES), .UNIT_W(3)) u_timer (
        .clk       (CLOCK_50),
        .rst_n     (rst),
        .restart_i (restart_s),
        .tick_o    (tick_s),
        .units_o   (units_s)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise_s) state_d = both_s ? ERR : MARK;
                else        state_d = IDLE;
            end
            MARK: begin
                if (!line_s)                              state_d = GAP;
                else if (tick_s && (units_s == MARK_LIMIT)) state_d = ERR;
                else                                      state_d = MARK;
            end
            GAP: begin
                if (rise_s)                               state_d = (both_s || (len_q == 3'd4)) ? ERR : MARK;
                else if (tick_s && (units_s == GAP_LAST)) state_d = DONE;
                else                                      state_d = GAP;
            end
            DONE: state_d = IDLE;
            ERR: begin
                if (!line_s && tick_s && (units_s == GAP_LAST)) state_d = IDLE;
                else                                            state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Symbol shift register and length; cleared whenever the FSM returns to IDLE.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            code_q <= 4'd0;
            len_q  <= 3'd0;
        end else if ((state_q == IDLE) && (state_d == MARK)) begin
            code_q <= {3'b000, dash_s};
            len_q  <= 3'd1;
        end else if ((state_q == GAP) && (state_d == MARK)) begin
            code_q <= {code_q[2:0], dash_s};
            len_q  <= len_q + 3'd1;
        end else if (state_d == IDLE) begin
            code_q <= 4'd0;
            len_q  <= 3'd0;
        end else begin
            code_q <= code_q;
            len_q  <= len_q;
        end
    end

    // FSM output logic; results are registered so they line up with the DONE/ERR cycle.
    always_comb begin
        lookup_s  = morse_lookup(code_q, len_q);
        valid_d   = (state_d == DONE) && lookup_s.hit;
        err_d     = ((state_d == DONE) && !lookup_s.hit) || ((state_d == ERR) && (state_q != ERR));
        busy_d    = (state_d != IDLE);
        if (valid_d) begin
            letter_d  = lookup_s.idx;
            len_out_d = len_q;
        end else begin
            letter_d  = letter_q;
            len_out_d = len_out_q;
        end
    end

    // Output registers.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            letter_q  <= 3'd0;
            len_out_q <= 3'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            letter_q  <= letter_d;
            len_out_q <= len_out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rx.letter_o = letter_q;
    assign rx.len_o    = len_out_q;
    assign rx.valid_o  = valid_q;
    assign rx.err_o    = err_q;
    assign rx.busy_o   = busy_q;

endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: directed boundary steps plus randomized letters
// checked against a pattern-string reference model.
module tb_morse_receiver;

    localparam int TICK = 4;
    localparam int GAPU = 3;
    localparam int MAXM = 4;
`ifdef MORSE_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   vcnt = 0;
    int   ecnt = 0;
    int   both_cnt = 0;
    int   exp_letter = 0;
    int   exp_len = 0;

    string MORSE [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_receiver_if rx_if ();

    morse_receiver #(.TICK_CYCLES(TICK), .GAP_UNITS(GAPU), .MAX_MARK_UNITS(MAXM)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .rx       (rx_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_if.valid_o === 1'b1) vcnt++;
        if (rx_if.err_o === 1'b1) ecnt++;
        if ((rx_if.valid_o === 1'b1) && (rx_if.err_o === 1'b1)) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void predict(input string pat, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        if (pat.len() <= 4) begin
            for (int k = 0; k < 8; k++) begin
                if (MORSE[k] == pat) begin
                    hit = 1'b1;
                    idx = k;
                end
            end
        end
    endfunction

    // mark/gap of 0 means random length per symbol
    task automatic send(input string pat, input int mark, input int gap);
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == 8'h2D) rx_if.dash_i = 1'b1;
            else                 rx_if.dot_i  = 1'b1;
            cyc((mark > 0) ? mark : int'($urandom_range(1, 12)));
            rx_if.dot_i  = 1'b0;
            rx_if.dash_i = 1'b0;
            if (i != pat.len() - 1) cyc((gap > 0) ? gap : int'($urandom_range(1, 8)));
        end
    endtask

    task automatic run_letter(input string tag, input string pat, input int mark, input int gap);
        int v0, e0, idx;
        bit hit;
        v0 = vcnt;
        e0 = ecnt;
        send(pat, mark, gap);
        cyc(20 + SYNC_LAT);
        predict(pat, hit, idx);
        if (hit) begin
            exp_letter = idx;
            exp_len    = pat.len();
        end
        check({tag, " valid"},  vcnt - v0, hit ? 1 : 0);
        check({tag, " err"},    ecnt - e0, hit ? 0 : 1);
        check({tag, " letter"}, rx_if.letter_o, exp_letter);
        check({tag, " len"},    rx_if.len_o, exp_len);
        check({tag, " busy"},   rx_if.busy_o, 0);
    endtask

    initial begin
        int lat, e0;
        string pat;

        rx_if.dot_i  = 1'b0;
        rx_if.dash_i = 1'b0;
        cyc(3);
        check("reset outs", {rx_if.letter_o, rx_if.len_o, rx_if.valid_o, rx_if.err_o, rx_if.busy_o}, 0);
        rst = 1'b1;
        cyc(2);

        // Test 1: single dot -> E, with exact latency from the falling edge
        e0 = vcnt;
        rx_if.dot_i = 1'b1;
        cyc(4);
        rx_if.dot_i = 1'b0;
        lat = 99;
        for (int n = 1; n <= 30; n++) begin
            cyc(1);
            if (rx_if.valid_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("E latency", lat, GAPU * TICK + 1 + SYNC_LAT);
        check("E letter", rx_if.letter_o, 4);
        check("E len", rx_if.len_o, 1);
        cyc(10);
        check("E one pulse", vcnt - e0, 1);
        exp_letter = 4;
        exp_len    = 1;

        // Test 2..4: directed letters with 4-clock marks and gaps
        run_letter("C", "-.-.", 4, 4);
        run_letter("five dots", ".....", 4, 4);
        run_letter("dash x3", "---", 4, 4);

        // Test 5: stuck dash line
        e0 = ecnt;
        rx_if.dash_i = 1'b1;
        cyc(20 + SYNC_LAT);
        check("stuck no err yet", rx_if.err_o, 0);
        check("stuck busy", rx_if.busy_o, 1);
        cyc(1);
        check("stuck err", rx_if.err_o, 1);
        cyc(3 - SYNC_LAT);
        rx_if.dash_i = 1'b0;
        cyc(11 + SYNC_LAT);
        check("stuck still busy", rx_if.busy_o, 1);
        cyc(1);
        check("stuck idle", rx_if.busy_o, 0);
        check("stuck err count", ecnt - e0, 1);
        check("stuck letter", rx_if.letter_o, exp_letter);

        // Test 6: reset mid-letter, then clean E
        send(".-", 4, 4);
        cyc(2);
        rst = 1'b0;
        #1;
        check("midrst outs", {rx_if.letter_o, rx_if.len_o, rx_if.valid_o, rx_if.err_o, rx_if.busy_o}, 0);
        cyc(2);
        rst = 1'b1;
        exp_letter = 0;
        exp_len    = 0;
        cyc(2);
        run_letter("post-rst E", ".", 4, 4);

        // Randomized letters of 1..5 symbols with random mark and gap lengths
        for (int t = 0; t < 24; t++) begin
            int len;
            len = $urandom_range(1, 5);
            pat = "";
            for (int s = 0; s < len; s++) pat = {pat, ($urandom_range(0, 1) == 1) ? "-" : "."};
            run_letter($sformatf("rnd%0d %s", t, pat), pat, 0, 0);
        end

        check("valid&err overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
